// File: rtl/serial_subtractor_8bit_if.sv
// Purpose: request/result bundle between a requester and the bit-serial subtractor.
// Latency: none, wires only.
// Backpressure: none carried here; the requester watches busy/done.
interface serial_subtractor_8bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             busy;
    logic             done;

    // Requester side: issues operands, observes the result.
    modport master (
        output start, a, b,
        input  diff, bout, ovf, busy, done
    );

    // Subtractor side: consumes operands, produces the result.
    modport slave (
        input  start, a, b,
        output diff, bout, ovf, busy, done
    );
endinterface

// File: rtl/serial_subtractor_8bit.sv
// Purpose: bit-serial a - b, LSB first, with borrow-out and signed-overflow flags.
// Latency: WIDTH cycles from the accepting edge to the done pulse; WIDTH+2 between starts.
// Backpressure: start is only looked at in IDLE; requests during RUN/DONE are dropped.
module serial_subtractor_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_subtractor_8bit_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             sign_a;
    logic             sign_b;

    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;

    // Full-subtractor cell applied to the current LSBs.
    logic             x;
    logic             y;
    logic             d;
    logic             br_nxt;
    logic [WIDTH-1:0] sr_nxt;
    logic             last_bit;

    assign x        = sa[0];
    assign y        = sb[0];
    assign d        = x ^ y ^ br;
    assign br_nxt   = (~x & y) | (~(x ^ y) & br);
    assign sr_nxt   = {d, sr[WIDTH-1:1]};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, leave RUN after the MSB, DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operands, shift one bit per RUN cycle, publish on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa     <= bus.a;
                        sb     <= bus.b;
                        sign_a <= bus.a[WIDTH-1];
                        sign_b <= bus.b[WIDTH-1];
                        br     <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= sr_nxt;
                    br  <= br_nxt;
                    cnt <= cnt + CW'(1);
                    if (last_bit) begin
                        // d is the result MSB here, so overflow needs no extra state.
                        diff_q <= sr_nxt;
                        bout_q <= br_nxt;
                        ovf_q  <= (sign_a != sign_b) & (d != sign_a);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Purpose: self-checking bench for serial_subtractor_8bit against an arithmetic reference.
// Latency: expects done WIDTH cycles after accept and WIDTH+2 cycles between back-to-back ops.
// Backpressure: drives start only when the block is expected to be idle, except the ignored-start test.
module tb_serial_subtractor_8bit;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    serial_subtractor_8bit_if #(.WIDTH(W)) bus ();

    serial_subtractor_8bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands.
    function automatic void ref_sub(input logic [7:0] ra, input logic [7:0] rb,
                                    output logic [7:0] rd, output logic rbo, output logic rov);
        int ua, ub, sa, sb, sd;
        ua  = int'(ra);
        ub  = int'(rb);
        sa  = (ua >= 128) ? ua - 256 : ua;
        sb  = (ub >= 128) ? ub - 256 : ub;
        sd  = sa - sb;
        rd  = 8'((ua - ub + 256) % 256);
        rbo = (ua < ub);
        rov = (sd > 127) || (sd < -128);
    endfunction

    // Stimulus helper: one-cycle start, then watch until done (bounded).
    task automatic run_single(input logic [7:0] ra, input logic [7:0] rb,
                              output logic [7:0] od, output logic obo, output logic oov,
                              output int lat, output int busy_cycles, output int both_hi);
        bus.a     = ra;
        bus.b     = rb;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.a       = 8'($urandom);
        bus.b       = 8'($urandom);
        lat         = -1;
        busy_cycles = bus.busy ? 1 : 0;
        both_hi     = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (bus.busy && bus.done) both_hi++;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) busy_cycles++;
        end
        od  = bus.diff;
        obo = bus.bout;
        oov = bus.ovf;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.diff, bus.bout, bus.ovf, bus.busy, bus.done} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got diff=%h bout=%b ovf=%b busy=%b done=%b, want all 0",
                     bus.diff, bus.bout, bus.ovf, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_quiet[%0d]: got busy=%b done=%b, want 0 0", i, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] d;
        logic bo, ov;
        int lat, bc, bh;
        run_single(8'h55, 8'hAA, d, bo, ov, lat, bc, bh);
        tests_run++;
        if (lat !== 8 || bc !== 8 || bh !== 0) begin
            tests_failed++;
            $display("FAIL basic_timing: got latency=%0d busy_cycles=%0d overlap=%0d, want 8 8 0", lat, bc, bh);
        end
        tests_run++;
        if (d !== 8'hAB || bo !== 1'b1 || ov !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_result: got diff=%h bout=%b ovf=%b, want ab 1 1", d, bo, ov);
        end
        tests_run++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done_pulse: got done=%b busy=%b one cycle later, want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_edges();
        logic [7:0] ta [3] = '{8'h00, 8'h80, 8'hFF};
        logic [7:0] tb [3] = '{8'h01, 8'h01, 8'hFF};
        logic [7:0] ed [3] = '{8'hFF, 8'h7F, 8'h00};
        logic       eb [3] = '{1'b1, 1'b0, 1'b0};
        logic       eo [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] d;
        logic bo, ov;
        int lat, bc, bh;
        for (int i = 0; i < 3; i++) begin
            run_single(ta[i], tb[i], d, bo, ov, lat, bc, bh);
            tests_run++;
            if (d !== ed[i] || bo !== eb[i] || ov !== eo[i] || lat !== 8) begin
                tests_failed++;
                $display("FAIL edge_%h_minus_%h: got diff=%h bout=%b ovf=%b lat=%0d, want %h %b %b 8",
                         ta[i], tb[i], d, bo, ov, lat, ed[i], eb[i], eo[i]);
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [7:0] prev_d;
        logic prev_b, prev_o;
        int ndone, held_bad;
        prev_d = bus.diff;
        prev_b = bus.bout;
        prev_o = bus.ovf;
        bus.a     = 8'h10;
        bus.b     = 8'h01;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone     = 0;
        held_bad  = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 3) begin
                bus.a = 8'h00;
                bus.b = 8'h00;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.done) begin
                ndone++;
                if (ndone == 1) begin
                    tests_run++;
                    if (bus.diff !== 8'h0F || bus.bout !== 1'b0 || bus.ovf !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL ignored_start_result: got diff=%h bout=%b ovf=%b, want 0f 0 0",
                                 bus.diff, bus.bout, bus.ovf);
                    end
                end
            end else if (ndone == 0) begin
                if (bus.diff !== prev_d || bus.bout !== prev_b || bus.ovf !== prev_o) held_bad++;
            end
        end
        bus.start = 1'b0;
        tests_run++;
        if (ndone !== 1) begin
            tests_failed++;
            $display("FAIL ignored_start_done_count: got %0d done pulses, want 1", ndone);
        end
        tests_run++;
        if (held_bad !== 0) begin
            tests_failed++;
            $display("FAIL ignored_start_hold: outputs changed %0d times before done, want 0", held_bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic bo, ov;
        int lat, bc, bh, ndone;
        bus.a     = 8'h5A;
        bus.b     = 8'h23;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.diff, bus.bout, bus.ovf, bus.busy, bus.done} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got diff=%h bout=%b ovf=%b busy=%b done=%b, want all 0",
                     bus.diff, bus.bout, bus.ovf, bus.busy, bus.done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) ndone++;
        end
        tests_run++;
        if (ndone !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_quiet: got %0d busy/done cycles after abort, want 0", ndone);
        end
        run_single(8'h30, 8'h10, d, bo, ov, lat, bc, bh);
        tests_run++;
        if (d !== 8'h20 || bo !== 1'b0 || ov !== 1'b0 || lat !== 8) begin
            tests_failed++;
            $display("FAIL reset_mid_fresh: got diff=%h bout=%b ovf=%b lat=%0d, want 20 0 0 8", d, bo, ov, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        logic [7:0] ea, eb, ed;
        logic ebo, eov;
        int cyc, last, ndone, bad_res, bad_gap, overlap;
        cyc = 0; last = -1; ndone = 0; bad_res = 0; bad_gap = 0; overlap = 0;
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        qa.push_back(bus.a);
        qb.push_back(bus.b);
        bus.start = 1'b1;
        while (ndone < 1000 && cyc < 10200) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.busy && bus.done) overlap++;
            if (bus.done) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                ref_sub(ea, eb, ed, ebo, eov);
                tests_run++;
                if (bus.diff !== ed || bus.bout !== ebo || bus.ovf !== eov) begin
                    tests_failed++;
                    bad_res++;
                    if (bad_res <= 5)
                        $display("FAIL b2b_result[%0d] %h-%h: got diff=%h bout=%b ovf=%b, want %h %b %b",
                                 ndone, ea, eb, bus.diff, bus.bout, bus.ovf, ed, ebo, eov);
                end
                if (last >= 0 && cyc - last != W + 2) bad_gap++;
                last = cyc;
                ndone++;
                if (ndone < 1000) begin
                    bus.a = 8'($urandom);
                    bus.b = 8'($urandom);
                    qa.push_back(bus.a);
                    qb.push_back(bus.b);
                end
            end
        end
        bus.start = 1'b0;
        tests_run++;
        if (ndone !== 1000) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d done pulses within budget, want 1000", ndone);
        end
        tests_run++;
        if (bad_gap !== 0) begin
            tests_failed++;
            $display("FAIL b2b_spacing: got %0d gaps not equal to %0d cycles, want 0", bad_gap, W + 2);
        end
        tests_run++;
        if (overlap !== 0) begin
            tests_failed++;
            $display("FAIL b2b_busy_done_overlap: got %0d cycles with both high, want 0", overlap);
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_edges();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/serial_subtractor_8bit.md
# serial_subtractor_8bit

Bit-serial unsigned/two's-complement subtractor computing `a - b` one bit per clock, LSB first, with a start/busy/done handshake. It is the inverse-operation companion to the combinational 8-bit ripple adder and shares its operand width and carry/borrow conventions. It is used where area matters more than latency, and by the adder benches as a cross-check: `(a + b) - b == a`.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Must be ≥ 2.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `start`  input  1  request. Sampled only in IDLE.
- `a`  input  WIDTH  minuend. Captured on the accepting edge.
- `b`  input  WIDTH  subtrahend. Captured on the accepting edge.
- `diff`  output  WIDTH  result `a - b` mod 2^WIDTH. Registered.
- `bout`  output  1  borrow out; 1 iff `a < b` unsigned. Registered.
- `ovf`  output  1  signed overflow flag. Registered.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse marking a new valid result.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - When `start`=1, capture `a`→`sa` and `b`→`sb` shift registers.
  - Clear the borrow flop `br` and the bit counter `cnt`, then go to RUN.
  - `start`=0 keeps the block in IDLE.
- RUN: each cycle, on bit `x=sa[0]`, `y=sb[0]`:
  - `d = x ^ y ^ br`
  - `br' = (~x & y) | (~(x ^ y) & br)`
  - `d` shifts into the MSB of internal result register `sr`; `sa` and `sb` shift right; `cnt` increments.
  - On the edge processing bit `WIDTH-1`, go to DONE.
  - On that same edge, load `diff` with the final `sr` including this bit, set `bout = br'`, and set `ovf = (a[W-1] != b[W-1]) & (diff[W-1] != a[W-1])`.
  - Capture the captured operands' sign bits at start so `ovf` can be computed.
- DONE: `done`=1 for exactly this cycle, then unconditionally go to IDLE.
- `start` in RUN or DONE is ignored. No queuing and no error flag.
- `diff`, `bout` and `ovf` change only on the completion edge. They hold the last result until the next completion, and partial results are never visible.
- `a` and `b` may change freely after the accepting edge.
- `cnt` width is `$clog2(WIDTH)`. `cnt` wraps safely because the exit happens at `cnt == WIDTH-1`.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE; `diff`=0, `bout`=0, `ovf`=0, `busy`=0, `done`=0; internal `sa`, `sb`, `sr`, `br`, `cnt` all 0.
- Reset asserted mid-RUN aborts the operation immediately. No `done` is produced, and outputs return to reset values.
- Accepting edge E0 (IDLE, `start`=1): `busy`=1 from E0.
- Bits are processed on edges E1..E_WIDTH. Results and `done`=1 appear after E_WIDTH, with `busy`=0 in the same cycle.
- `done` falls after E_WIDTH+1, when the block is back in IDLE.
- Latency from accept to `done`: WIDTH cycles (8 at default).
- Minimum start-to-start spacing: WIDTH+2 cycles. A `start` held high continuously is re-accepted on the first IDLE edge.
- `busy` and `done` are never high together.

## Test plan
- Reset then idle: `rst_n` low 2 cycles → all outputs 0. `start`=0 for 20 cycles → `busy`, `done` stay 0.
- `a`=0x55, `b`=0xAA, one-cycle `start` → `busy` for 8 cycles, `done` pulse exactly 8 cycles after accept, `diff`=0xAB, `bout`=1, `ovf`=1.
- Edge values, each run separately:
  - 0x00−0x01 → `diff`=0xFF, `bout`=1, `ovf`=0
  - 0x80−0x01 → 0x7F, `bout`=0, `ovf`=1
  - 0xFF−0xFF → 0x00, `bout`=0, `ovf`=0
- Ignored start: start 0x10−0x01, pulse `start` with 0x00/0x00 at cycle 3 of RUN → single `done`, `diff`=0x0F. Outputs stay unchanged until that `done`.
- Reset mid-operation: assert `rst_n` low asynchronously (between edges) at cycle 4 of RUN → outputs 0 immediately, no `done`. A fresh 0x30−0x10 then yields `diff`=0x20.
- Random regression: 1000 back-to-back ops with `start` held high, compared against `a-b`, `a<b` and the signed-overflow reference model. Check one `done` per WIDTH+2 cycles.
